// File: rtl/sram_arb2.sv
// Two-master arbiter for one single-port SRAM: combinational grant, lockable round-robin priority.
// Latency: grant in the request cycle, read data one cycle later; a losing requester simply retries.
module sram_arb2 #(
    parameter int WD       = 128,
    parameter int DEPTH    = 64,
    parameter int WA       = $clog2(DEPTH),
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [WA-1:0] m0_addr,
    input  logic [WD-1:0] m0_wdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [WA-1:0] m1_addr,
    input  logic [WD-1:0] m1_wdata,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [WD-1:0] rdata,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [WA-1:0] mem_addr,
    output logic [WD-1:0] mem_din,
    input  logic [WD-1:0] mem_dout
);

    localparam int LW = $clog2(MAX_LOCK + 1);

    logic          prio;
    logic [LW-1:0] lcnt;
    logic          rv0_q;
    logic          rv1_q;
    logic          own_lock;
    logic          keep;

    assign m0_gnt = !rst && m0_req && (!m1_req || !prio);
    assign m1_gnt = !rst && m1_req && (!m0_req ||  prio);

    assign mem_cs   = m0_gnt || m1_gnt;
    assign mem_we   = m1_gnt ? m1_we    : (m0_gnt && m0_we);
    assign mem_addr = m1_gnt ? m1_addr  : m0_addr;
    assign mem_din  = m1_gnt ? m1_wdata : m0_wdata;

    // Reset also masks a read already in flight so it never surfaces.
    assign m0_rvalid = rv0_q && !rst;
    assign m1_rvalid = rv1_q && !rst;
    assign rdata     = mem_dout;

    assign own_lock = m1_gnt ? m1_lock : m0_lock;
    assign keep     = own_lock && (lcnt < LW'(MAX_LOCK - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            prio  <= 1'b0;
            lcnt  <= '0;
            rv0_q <= 1'b0;
            rv1_q <= 1'b0;
        end else begin
            rv0_q <= m0_gnt && !m0_we;
            rv1_q <= m1_gnt && !m1_we;
            if (mem_cs) begin
                if (keep) begin
                    prio <= m1_gnt;
                    lcnt <= lcnt + 1'b1;
                end else begin
                    prio <= !m1_gnt;
                    lcnt <= '0;
                end
            end
        end
    end

endmodule
